load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer (IDLE/WAIT/WB) with alignment checks, lane steering, ack timeout
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, WB} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        load_q, load_d;
  logic        dmem_req_q, dmem_req_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_we_q, dmem_we_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        bad;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ext;
  logic [3:0]  mask;
  logic [31:0] wdata;
  assign bad = (is_load == is_store)
             || (is_load && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
             || (is_store && funct3 > 3'b010)
             || (funct3[1:0] == 2'b01 && addr[0])
             || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign mask  = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                 funct3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
  assign wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                 funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
  assign lb  = 8'(dmem_rdata >> {lane_q, 3'b000});
  assign lh  = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign ext = f3_q == 3'b000 ? {{24{lb[7]}}, lb} :
               f3_q == 3'b001 ? {{16{lh[15]}}, lh} :
               f3_q == 3'b100 ? {24'b0, lb} :
               f3_q == 3'b101 ? {16'b0, lh} : dmem_rdata;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lane_d       = lane_q;
    f3_d         = f3_q;
    rd_d         = rd_q;
    load_d       = load_q;
    dmem_req_d   = dmem_req_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_we_d    = dmem_we_q;
    dmem_wdata_d = dmem_wdata_q;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wdata_d   = rf_wdata_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        if (bad) begin
          err_d = 1'b1;
        end else begin
          state_d      = WAIT;
          cnt_d        = 8'd0;
          lane_d       = addr[1:0];
          f3_d         = funct3;
          rd_d         = rd_in;
          load_d       = is_load;
          dmem_req_d   = 1'b1;
          dmem_addr_d  = {addr[31:2], 2'b00};
          dmem_we_d    = is_store ? mask : 4'b0000;
          dmem_wdata_d = wdata;
        end
      end
      WAIT: if (dmem_ack) begin
        dmem_req_d = 1'b0;
        dmem_we_d  = 4'b0000;
        done_d     = 1'b1;
        state_d    = load_q ? WB : IDLE;
        rf_we_d    = load_q && rd_q != 5'd0;
        rf_rd_d    = load_q ? rd_q : rf_rd_q;
        rf_wdata_d = load_q ? ext : rf_wdata_q;
      end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
        dmem_req_d = 1'b0;
        dmem_we_d  = 4'b0000;
        err_d      = 1'b1;
        state_d    = IDLE;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      WB: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lane_q       <= '0;
      f3_q         <= '0;
      rd_q         <= '0;
      load_q       <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_we_q    <= '0;
      dmem_wdata_q <= '0;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      f3_q         <= f3_d;
      rd_q         <= rd_d;
      load_q       <= load_d;
      dmem_req_q   <= dmem_req_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_we_q    <= dmem_we_d;
      dmem_wdata_q <= dmem_wdata_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign req_ready  = state_q == IDLE;
  assign dmem_req   = dmem_req_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_wdata = dmem_wdata_q;
  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wdata   = rf_wdata_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule
